// File: rtl/counter_bank_pkg.sv
// Shared constants and helpers for the counter bank and its event arbiter.
package counter_bank_pkg;

    localparam int DEF_NCH    = 4;
    localparam int DEF_WIDTH  = 5;
    localparam int DEF_PERIOD = 10;

    // Index width for n items; a single item still needs a 1-bit field.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Reverse the low w bits of v; bits above w come back as zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < 32; j++) begin
            r[j] = v[31-j];
        end
        return r >> (32 - w);
    endfunction

endpackage

// File: rtl/counter_bank_rr_arbiter.sv
// Round-robin arbiter: N requests -> one-hot grant plus index.
// The pointer holds the first channel to consider and moves past each taken grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] ptr_q;
    logic [N-1:0]  upper;

    always_comb begin
        upper = '0;
        gnt   = '0;
        idx   = '0;
        any   = |req;
        for (int i = 0; i < N; i++) begin
            upper[i] = req[i] && (IW'(i) >= ptr_q);
        end
        // Lowest request at/after the pointer, else lowest overall (wrap-around).
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
        if (|upper) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (upper[i]) idx = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            gnt[i] = any && (idx == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (adv && any) begin
            ptr_q <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/counter_bank.sv
// Bank of prescaled step counters; every value change is reported once on an event port.
// ev_valid_o/ev_ready_i: a transfer happens on a rising edge with both high; while valid and not ready the payload holds.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int             NCH    = DEF_NCH,
    parameter int             WIDTH  = DEF_WIDTH,
    parameter int             PERIOD = DEF_PERIOD,
    parameter logic [NCH-1:0] BITREV = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          en_i,
    input  logic [NCH-1:0]          down_i,
    input  logic [NCH-1:0]          sat_i,
    input  logic [NCH-1:0]          load_i,
    input  logic [NCH*WIDTH-1:0]    load_val_i,
    output logic [NCH*WIDTH-1:0]    cnt_o,
    output logic                    ev_valid_o,
    input  logic                    ev_ready_i,
    output logic [idx_w(NCH)-1:0]   ev_ch_o,
    output logic [WIDTH-1:0]        ev_val_o,
    output logic [NCH-1:0]          overrun_o,
    input  logic                    clr_ovr_i
);

    localparam int CW = idx_w(NCH);
    localparam int PW = idx_w(PERIOD);
    localparam logic [WIDTH-1:0] MAXV = '1;

    logic [PW-1:0]    presc_q;
    logic             step;
    logic [WIDTH-1:0] cnt_q [NCH];
    logic [WIDTH-1:0] cnt_d [NCH];
    logic [NCH-1:0]   changed;
    logic [NCH-1:0]   pend_q;
    logic [NCH-1:0]   gnt;
    logic [NCH-1:0]   granted;
    logic [CW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             take;
    logic [WIDTH-1:0] sel_val;

    assign step = (presc_q == PW'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (rst)       presc_q <= '0;
        else if (step) presc_q <= '0;
        else           presc_q <= presc_q + 1'b1;
    end

    always_comb begin
        changed = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (load_i[i]) begin
                cnt_d[i] = load_val_i[i*WIDTH +: WIDTH];
            end else if (step && en_i[i]) begin
                if (down_i[i]) begin
                    if (cnt_q[i] != '0 || !sat_i[i]) cnt_d[i] = cnt_q[i] - 1'b1;
                end else begin
                    if (cnt_q[i] != MAXV || !sat_i[i]) cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            changed[i] = (cnt_d[i] != cnt_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst) cnt_q[i] <= '0;
            else     cnt_q[i] <= cnt_d[i];
        end
    end

    // The output stage accepts a new event whenever it is empty or being drained.
    assign take    = !ev_valid_o || ev_ready_i;
    assign granted = take ? gnt : '0;

    rr_arbiter #(
        .N  (NCH),
        .IW (CW)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (pend_q),
        .adv (take),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) sel_val = cnt_q[i];
        end
    end

    // A change landing on a granted channel re-arms pending rather than counting as an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= '0;
            overrun_o <= '0;
        end else begin
            pend_q    <= (pend_q & ~granted) | changed;
            overrun_o <= (overrun_o & ~{NCH{clr_ovr_i}}) | (changed & pend_q & ~granted);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_valid_o <= 1'b0;
            ev_ch_o    <= '0;
            ev_val_o   <= '0;
        end else if (take) begin
            ev_valid_o <= gnt_any;
            if (gnt_any) begin
                ev_ch_o  <= gnt_idx;
                ev_val_o <= sel_val;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_out
        assign cnt_o[i*WIDTH +: WIDTH] = BITREV[i] ? WIDTH'(bit_rev(32'(cnt_q[i]), WIDTH))
                                                   : cnt_q[i];
    end

endmodule

// File: doc/counter_bank.md
# counter_bank

Parametrised bank of NCH free-running step counters with per-channel bit ordering, direction, wrap/saturate mode and synchronous load. Every value change is reported once through a valid/ready event port, so a monitor can log it the same way an `always @(value)` watcher would. The block is the synthesizable successor to the single-width, fixed-order counter tests. It sits between a stimulus or prescaled timebase and a logging/checking consumer.

## Interface
- NCH, 4, number of counter channels (1..16)
- WIDTH, 5, counter width in bits (2..32)
- PERIOD, 10, clock cycles per step tick (≥1)
- BITREV, 0, NCH-bit mask; bit i=1 presents channel i's bus MSB-first (emulates a [0:WIDTH-1] declaration)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- en_i  in  NCH  per-channel step enable
- down_i  in  NCH  1 = count down, 0 = up
- sat_i  in  NCH  1 = saturate at bounds, 0 = wrap
- load_i  in  NCH  per-channel load strobe
- load_val_i  in  NCH*WIDTH  load values, channel i at [i*WIDTH +: WIDTH], arithmetic order
- cnt_o  out  NCH*WIDTH  counter values, bit order per BITREV
- ev_valid_o  out  1  change event available
- ev_ready_i  in  1  consumer accepts event
- ev_ch_o  out  max(1,$clog2(NCH))  channel of the event
- ev_val_o  out  WIDTH  channel value at capture, arithmetic order
- overrun_o  out  NCH  sticky: a change was overwritten before it was reported
- clr_ovr_i  in  1  clears overrun_o

## Operation
- Prescaler counts 0..PERIOD-1. The step fires in the cycle where it equals PERIOD-1, then it wraps to 0. With PERIOD=1 the step fires every cycle.
- Per-channel next value, in priority order:
  - load_i → load_val_i
  - step && en_i → ±1
  - otherwise hold
- Up/wrap: 2^WIDTH-1 → 0. Down/wrap: 0 → 2^WIDTH-1.
- Saturate mode holds the value at 2^WIDTH-1 (up) or 0 (down).
- All arithmetic is unsigned modulo 2^WIDTH and is independent of BITREV. BITREV only reorders the cnt_o bits: out bit j = value bit WIDTH-1-j.
- Change detect: next ≠ current sets pending[i] and marks the channel changed. A hold, a saturated step or a load of an equal value produces no event.
- If pending[i] is already set and not being granted that cycle, a further change sets overrun[i]. The channel remains a single pending entry.
- Event stage: one output register. It loads when ev_valid_o=0 or (ev_valid_o && ev_ready_i).
  - The round-robin arbiter picks among pending channels, starting after the last grant.
  - The stage captures the channel's current register value, and the pending bit clears.
- Simultaneous grant and new change on the same channel: pending stays set, so the new value is reported later. This is not an overrun.
- clr_ovr_i clears overrun_o. A new overrun in the same cycle wins (bit stays set).

## Timing
- Reset values:
  - cnt_o = 0 and prescaler = 0
  - pending = 0 and overrun_o = 0
  - ev_valid_o = 0, ev_ch_o = 0, ev_val_o = 0
  - arbiter pointer = channel 0
- Reset mid-operation discards any held event.
- Load or step applied at edge N → cnt_o updates at edge N. The pending bit sets at N, and ev_valid_o can rise at edge N+1.
- ev_valid_o, ev_ch_o and ev_val_o are stable while ev_valid_o=1 and ev_ready_i=0.
- With ev_ready_i held high the port sustains one event per cycle.
- First step after reset occurs at edge PERIOD.

## Structure
- Package counter_bank_pkg: helper function for ev_ch_o width, bit-reverse function, and the default parameter constants.
- Sub-module rr_arbiter (NCH requests → one-hot grant plus index, with a rotating pointer). It is reusable by other monitors.
- Counters and event stage stay in counter_bank.

## Test plan
- Default params, BITREV=4'b1010, all en_i=1, up/wrap, ev_ready_i=1, run 100 cycles → 10 steps per channel; all reach 10. cnt_o[1] reads 5'b01010 reversed = 5'b01010 in MSB-first bit positions, and ev_val_o=10. 40 events in channel order 0,1,2,3 per step.
- Ch0 up/wrap loaded 31, one step → cnt 0, event val 0. Ch2 down/sat loaded 0, steps → no events, cnt stays 0.
- ev_ready_i=0 for 25 cycles with all channels stepping → ev_valid_o and its payload held, overrun_o=4'b1111. Then ev_ready_i=1 delivers the latest values. clr_ovr_i → overrun_o=0.
- load_i[3] with val 7 in the same cycle as a step → cnt 7 (load wins); load of 7 again → no event.
- rst asserted while ev_valid_o=1 and channels pending → next cycle all outputs 0, no event. The first step occurs PERIOD cycles after rst falls.
- PERIOD=1, NCH=1, WIDTH=2, up/wrap → cnt sequence 1,2,3,0,1… one per cycle. Events are continuous with ev_ready_i=1, and there is no overrun.
